// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: a stall-based load/store port with byte/half/word lanes.
// Optional macro DMEM_ALIGN_CHECK_EN enables misaligned-access detection and store suppression.
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        half,
   input  logic        b,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        misalign
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state_reg, state_next;
   logic [3:0]    cnt_reg;
   logic [AW-1:0] idx_reg;
   logic [3:0]    lane_en_reg;
   logic [31:0]   wdata_reg;
   logic          we_reg;
   logic          b_reg;
   logic          half_reg;
   logic [1:0]    off_reg;
   logic          mis_reg;

   logic          accept;
   logic [AW-1:0] rd_idx;
   logic [3:0]    lane_en_dec;
   logic [31:0]   wdata_dec;
   logic          mis_dec;
   logic          wr_go;
   logic [3:0]    lane_we;
   logic [31:0]   rd_word;
   logic [31:0]   rd_shift;
   logic          unused_addr;

   assign accept      = (state_reg == IDLE) && req;
   assign rd_idx      = addr[AW+1:2];
   assign unused_addr = ^addr[31:AW+2];

   // Lane enables and lane-replicated store data for the incoming access
   always_comb begin
      lane_en_dec = 4'b1111;
      wdata_dec   = wdata;
      if (b) begin
         lane_en_dec = 4'b0001 << addr[1:0];
         wdata_dec   = {4{wdata[7:0]}};
      end else if (half) begin
         lane_en_dec = addr[1] ? 4'b1100 : 4'b0011;
         wdata_dec   = {2{wdata[15:0]}};
      end
   end

`ifdef DMEM_ALIGN_CHECK_EN
   assign mis_dec = !b && ((half && addr[0]) || (!half && (addr[1:0] != 2'b00)));
`else
   assign mis_dec = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic; BUSY exits as the counter steps down to zero, so DONE sees it at 0
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (req) state_next = (WAIT_CYCLES == 0) ? DONE : BUSY;
         BUSY: begin
            if (!req)                 state_next = IDLE;
            else if (cnt_reg <= 4'd1) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Wait counter and access latches
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg <= 4'd0;
         mis_reg <= 1'b0;
      end else begin
         if (accept) begin
            cnt_reg <= 4'(WAIT_CYCLES);
            mis_reg <= mis_dec;
         end else if (state_reg == BUSY && cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         idx_reg     <= rd_idx;
         lane_en_reg <= lane_en_dec;
         wdata_reg   <= wdata_dec;
         we_reg      <= we;
         b_reg       <= b;
         half_reg    <= half;
         off_reg     <= addr[1:0];
      end
   end

   // Commit uses latched fields so a req drop during DONE cannot corrupt the store
   assign wr_go   = (state_reg == DONE) && we_reg && !mis_reg && !reset;
   assign lane_we = {4{wr_go}} & lane_en_reg;

   // One byte-wide RAM per lane with registered read
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH_WORDS];
         logic [7:0] q_reg;
         always_ff @(posedge clk) begin
            if (lane_we[gi]) mem[idx_reg] <= wdata_reg[8*gi +: 8];
            q_reg <= mem[rd_idx];
         end
         assign rd_word[8*gi +: 8] = q_reg;
      end
   endgenerate

   assign rd_shift = rd_word >> {off_reg, 3'b000};

   // Outputs; rd_word was captured at the edge entering DONE and holds through it
   always_comb begin
      stall    = req && (state_reg != DONE);
      misalign = (state_reg == DONE) && mis_reg;
      rdata    = 32'd0;
      if (state_reg == DONE && !we_reg && !mis_reg) begin
         if (b_reg)         rdata = {24'd0, rd_shift[7:0]};
         else if (half_reg) rdata = {16'd0, off_reg[1] ? rd_word[31:16] : rd_word[15:0]};
         else               rdata = rd_word;
      end
   end

endmodule
